// File: rtl/pcs_tx_scrambler_gearbox.sv
// 10GBASE-R TX scrambler (x^58 + x^39 + 1) and 66b->32b gearbox.
// Block payload is scrambled in stage 1; stage 2 repacks {payload, hdr} into a continuous 32-bit stream.
module pcs_tx_scrambler_gearbox #(
  parameter int DATA_WIDTH      = 32,
  parameter int HDR_WIDTH       = 2,
  parameter int SCRAMBLE_BYPASS = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_encoded_data,
  input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
  input  logic                  i_hdr_valid,
  output logic                  o_pause,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_align_err
);

  localparam logic [0:0] WAIT_SYNC = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;
  localparam int         BUF_WIDTH = 2 * DATA_WIDTH + HDR_WIDTH;
  localparam logic [5:0] LAST_CNT  = 6'd32;

  logic [0:0]            state_reg, state_next;
  logic [5:0]            seq_cnt_reg, seq_cnt_next;
  logic [57:0]           scr_state_reg, scr_state_next, lfsr;
  logic                  fb;
  logic [DATA_WIDTH-1:0] scr_data;
  logic                  align_err_reg;
  logic                  s1_valid_reg, s1_word_reg, s1_is_a_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;
  logic [HDR_WIDTH-1:0]  s1_hdr_reg;
  logic [BUF_WIDTH-1:0]  res_reg, res_next, in_vec, combined;
  logic [6:0]            r_reg, r_next, in_bits;
  logic [DATA_WIDTH-1:0] tx_reg, tx_next;
  logic                  in_run, pause, accept, is_a, misaligned;

  assign in_run     = (state_reg == RUN);
  assign pause      = in_run && (seq_cnt_reg == LAST_CNT);
  assign accept     = in_run ? !pause : i_hdr_valid;
  // seq_cnt sits at 0 in WAIT_SYNC, so the locking word is treated as word A
  assign is_a       = ~seq_cnt_reg[0];
  assign misaligned = in_run && !pause && (i_hdr_valid != is_a);

  always_comb begin
    state_next   = state_reg;
    seq_cnt_next = seq_cnt_reg;
    if (accept || pause) begin
      state_next   = RUN;
      seq_cnt_next = pause ? 6'd0 : seq_cnt_reg + 6'd1;
    end
  end

  always_comb begin
    lfsr     = scr_state_reg;
    scr_data = '0;
    fb       = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (SCRAMBLE_BYPASS != 0) fb = i_encoded_data[i];
      else                      fb = i_encoded_data[i] ^ lfsr[38] ^ lfsr[57];
      scr_data[i] = fb;
      lfsr        = {lfsr[56:0], fb};
    end
    scr_state_next = accept ? lfsr : scr_state_reg;
  end

  // New bits are appended above the R residue bits; the oldest 32 leave each cycle
  always_comb begin
    in_vec  = '0;
    in_bits = '0;
    if (s1_is_a_reg) begin
      in_vec  = BUF_WIDTH'({s1_data_reg, s1_hdr_reg});
      in_bits = 7'(DATA_WIDTH + HDR_WIDTH);
    end else if (s1_word_reg) begin
      in_vec  = BUF_WIDTH'(s1_data_reg);
      in_bits = 7'(DATA_WIDTH);
    end
    combined = res_reg | (in_vec << r_reg);
    tx_next  = '0;
    res_next = res_reg;
    r_next   = r_reg;
    if (s1_valid_reg) begin
      tx_next  = combined[DATA_WIDTH-1:0];
      res_next = combined >> DATA_WIDTH;
      r_next   = r_reg + in_bits - 7'(DATA_WIDTH);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= WAIT_SYNC;
      seq_cnt_reg   <= '0;
      scr_state_reg <= '1;
      align_err_reg <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_word_reg   <= 1'b0;
      s1_is_a_reg   <= 1'b0;
      s1_data_reg   <= '0;
      s1_hdr_reg    <= '0;
      res_reg       <= '0;
      r_reg         <= '0;
      tx_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      seq_cnt_reg   <= seq_cnt_next;
      scr_state_reg <= scr_state_next;
      align_err_reg <= align_err_reg | misaligned;
      s1_valid_reg  <= accept || pause;
      s1_word_reg   <= accept;
      s1_is_a_reg   <= accept && is_a;
      s1_data_reg   <= scr_data;
      if (accept && is_a) s1_hdr_reg <= i_sync_hdr;
      res_reg       <= res_next;
      r_reg         <= r_next;
      tx_reg        <= tx_next;
    end
  end

  assign o_pause     = pause;
  assign o_tx_data   = tx_reg;
  assign o_align_err = align_err_reg;

endmodule
